// File: rtl/vector_pkg.sv
// ============================================================================
//  Module      : vector_pkg
//  Description : Shared payload type, issue FSM states and beat limits for
//                the vector issue controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vector_pkg;

    localparam int VEX_OP_WIDTH = 128;
    localparam int VEX_BEAT_W   = 4;
    localparam int MAX_BEATS    = (1 << VEX_BEAT_W) - 1;

    typedef logic [VEX_OP_WIDTH-1:0] to_vector_alu;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_e;

endpackage

`default_nettype wire

// File: rtl/vex_issue_ctrl_if.sv
// ============================================================================
//  Module      : vex_issue_ctrl_if
//  Description : Requester-side and pipe-side handshake bundle of the issue
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vex_issue_ctrl_if #(
    parameter int NUM_REQ  = 2,
    parameter int OP_WIDTH = 128,
    parameter int BEAT_W   = 4,
    parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

    logic [NUM_REQ-1:0]          req_valid_i;
    logic [NUM_REQ-1:0]          req_ready_o;
    logic [NUM_REQ*OP_WIDTH-1:0] req_op_i;
    logic [NUM_REQ*BEAT_W-1:0]   req_beats_i;
    logic                        flush_i;
    logic                        pipe_valid_o;
    logic                        pipe_ready_i;
    logic [OP_WIDTH-1:0]         pipe_op_o;
    logic [BEAT_W-1:0]           pipe_beat_o;
    logic                        pipe_last_o;
    logic                        done_o;
    logic [ID_W-1:0]             done_id_o;
    logic                        busy_o;

    modport master (
        output req_valid_i, req_op_i, req_beats_i, flush_i, pipe_ready_i,
        input  req_ready_o, pipe_valid_o, pipe_op_o, pipe_beat_o, pipe_last_o,
               done_o, done_id_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_beats_i, flush_i, pipe_ready_i,
        output req_ready_o, pipe_valid_o, pipe_op_o, pipe_beat_o, pipe_last_o,
               done_o, done_id_o, busy_o
    );

endinterface

`default_nettype wire

// File: rtl/vex_issue_ctrl_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant search starting at a
//                supplied pointer; grants nothing while disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [ID_W-1:0]    i_ptr,
    input  wire logic               i_en,
    output logic      [NUM_REQ-1:0] o_grant,
    output logic      [ID_W-1:0]    o_grant_idx,
    output logic                    o_any_grant
);

    localparam logic [ID_W:0] c_NUM = (ID_W+1)'(NUM_REQ);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_j;

    // Visit requesters in order ptr, ptr+1, ... wrapping; first valid wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_sum       = '0;
        w_j         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            w_j = w_sum[ID_W-1:0];
            if (i_en && !o_any_grant && i_req[w_j]) begin
                o_grant[w_j] = 1'b1;
                o_grant_idx  = w_j;
                o_any_grant  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vex_issue_ctrl.sv
// ============================================================================
//  Module      : vex_issue_ctrl
//  Description : Round-robin issue controller sequencing multi-beat vector
//                operations into vex_pipe, one beat per pipe handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vex_issue_ctrl
    import vector_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int OP_WIDTH = VEX_OP_WIDTH,
    parameter int BEAT_W   = VEX_BEAT_W,
    parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    vex_issue_ctrl_if.slave  bus
);

    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

    issue_state_e          r_state;
    logic [OP_WIDTH-1:0]   r_op;
    logic [BEAT_W-1:0]     r_beat;
    logic [BEAT_W-1:0]     r_beats_eff;
    logic [ID_W-1:0]       r_id;
    logic [ID_W-1:0]       r_ptr;

    logic                  w_busy;
    logic                  w_last;
    logic                  w_fire;
    logic                  w_last_fire;
    logic                  w_accept_en;
    logic                  w_done;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_grant_idx;
    logic                  w_any_grant;
    logic [OP_WIDTH-1:0]   w_sel_op;
    logic [BEAT_W-1:0]     w_sel_beats;
    logic [BEAT_W-1:0]     w_sel_beats_eff;
    logic [ID_W-1:0]       w_ptr_next;

    assign w_busy      = (r_state == ISSUE);
    assign w_last      = (r_beat == r_beats_eff - BEAT_W'(1));
    assign w_fire      = w_busy & bus.pipe_ready_i;
    assign w_last_fire = w_fire & w_last;
    // rst_n is active-high; no grant is offered while reset is asserted.
    assign w_accept_en = ~rst_n & ~bus.flush_i & (~w_busy | w_last_fire);
    assign w_done      = w_last_fire & ~bus.flush_i & ~rst_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req       (bus.req_valid_i),
        .i_ptr       (r_ptr),
        .i_en        (w_accept_en),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    always_comb begin
        w_sel_op    = '0;
        w_sel_beats = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_op    = bus.req_op_i[i*OP_WIDTH +: OP_WIDTH];
                w_sel_beats = bus.req_beats_i[i*BEAT_W +: BEAT_W];
            end
        end
    end

    assign w_sel_beats_eff = (w_sel_beats == '0) ? BEAT_W'(1) : w_sel_beats;
    assign w_ptr_next      = (w_grant_idx == c_LAST_ID) ? '0 : w_grant_idx + ID_W'(1);

    // A new accept takes priority over completion so back-to-back ops stay in ISSUE.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_beat      <= '0;
            r_beats_eff <= '0;
            r_id        <= '0;
            r_ptr       <= '0;
        end else if (bus.flush_i) begin
            r_state <= IDLE;
        end else if (w_any_grant) begin
            r_state     <= ISSUE;
            r_op        <= w_sel_op;
            r_beats_eff <= w_sel_beats_eff;
            r_id        <= w_grant_idx;
            r_beat      <= '0;
            r_ptr       <= w_ptr_next;
        end else if (w_last_fire) begin
            r_state <= IDLE;
        end else if (w_fire) begin
            r_beat <= r_beat + BEAT_W'(1);
        end
    end

    assign bus.req_ready_o  = w_grant;
    assign bus.pipe_valid_o = w_busy;
    assign bus.pipe_op_o    = r_op;
    assign bus.pipe_beat_o  = r_beat;
    assign bus.pipe_last_o  = w_busy & w_last;
    assign bus.done_o       = w_done;
    assign bus.done_id_o    = w_done ? r_id : '0;
    assign bus.busy_o       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_vex_issue_ctrl.sv
// ============================================================================
//  Module      : tb_vex_issue_ctrl
//  Description : Directed plus short random bench for vex_issue_ctrl with a
//                reference model and expected-operation scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vex_issue_ctrl;
    import vector_pkg::*;

    localparam int NUM_REQ  = 2;
    localparam int OP_WIDTH = 128;
    localparam int BEAT_W   = 4;
    localparam int ID_W     = 1;

    typedef struct {
        logic [ID_W-1:0] id;
        to_vector_alu    op;
        int              beats;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    vex_issue_ctrl_if #(
        .NUM_REQ(NUM_REQ), .OP_WIDTH(OP_WIDTH), .BEAT_W(BEAT_W), .ID_W(ID_W)
    ) bus ();

    vex_issue_ctrl #(
        .NUM_REQ(NUM_REQ), .OP_WIDTH(OP_WIDTH), .BEAT_W(BEAT_W), .ID_W(ID_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic m_busy   = 1'b0;
    int   m_beat   = 0;
    int   m_ptr    = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic v, input int beats);
        bus.req_valid_i[idx] = v;
        bus.req_beats_i[idx*BEAT_W +: BEAT_W] = BEAT_W'(beats);
        bus.req_op_i[idx*OP_WIDTH +: OP_WIDTH] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Compare every observable output against the model, then advance the model.
    task automatic check_cycle();
        logic [NUM_REQ-1:0] exp_ready;
        logic               last_fire;
        logic               exp_done;
        int                 g;
        int                 b;
        exp_t               e;
        exp_ready = '0;
        g         = -1;
        last_fire = m_busy && bus.pipe_ready_i && (m_beat == sb[0].beats - 1);
        exp_done  = last_fire && !bus.flush_i && !rst_n;

        chk("pipe_valid", 128'(bus.pipe_valid_o), 128'(m_busy));
        chk("busy", 128'(bus.busy_o), 128'(m_busy));
        if (m_busy) begin
            chk("pipe_op", bus.pipe_op_o, sb[0].op);
            chk("pipe_beat", 128'(bus.pipe_beat_o), 128'(m_beat));
            chk("pipe_last", 128'(bus.pipe_last_o), 128'(m_beat == sb[0].beats - 1));
        end
        chk("done", 128'(bus.done_o), 128'(exp_done));
        chk("done_id", 128'(bus.done_id_o), exp_done ? 128'(sb[0].id) : 128'(0));

        if (!rst_n && !bus.flush_i && (!m_busy || last_fire)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && bus.req_valid_i[(m_ptr + k) % NUM_REQ]) begin
                    g = (m_ptr + k) % NUM_REQ;
                end
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 128'(bus.req_ready_o), 128'(exp_ready));

        if (rst_n) begin
            sb.delete();
            m_busy = 1'b0;
            m_beat = 0;
            m_ptr  = 0;
        end else if (bus.flush_i) begin
            if (m_busy) void'(sb.pop_front());
            m_busy = 1'b0;
        end else begin
            if (last_fire) begin
                void'(sb.pop_front());
                m_busy = 1'b0;
            end else if (m_busy && bus.pipe_ready_i) begin
                m_beat++;
            end
            if (g >= 0) begin
                b       = int'(bus.req_beats_i[g*BEAT_W +: BEAT_W]);
                e.id    = ID_W'(g);
                e.op    = bus.req_op_i[g*OP_WIDTH +: OP_WIDTH];
                e.beats = (b == 0) ? 1 : b;
                sb.push_back(e);
                m_busy = 1'b1;
                m_beat = 0;
                m_ptr  = (g + 1) % NUM_REQ;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid_i  = '0;
        bus.req_op_i     = '0;
        bus.req_beats_i  = '0;
        bus.flush_i      = 1'b0;
        bus.pipe_ready_i = 1'b1;

        // Reset held two cycles with req0 pending.
        set_req(0, 1'b1, 3);
        @(posedge clk);
        #1;
        chk("rst_pipe_op", bus.pipe_op_o, 128'(0));
        chk("rst_pipe_beat", 128'(bus.pipe_beat_o), 128'(0));
        tick();
        tick();
        rst_n = 1'b0;

        // 3-beat op from req0: beats 0..2 in cycles 1..3, done in cycle 3.
        tick();
        set_req(0, 1'b0, 0);
        repeat (4) tick();

        // Round-robin with both requesters valid and single-beat ops.
        set_req(0, 1'b1, 1);
        set_req(1, 1'b1, 1);
        repeat (8) tick();
        set_req(0, 1'b0, 0);
        set_req(1, 1'b0, 0);
        repeat (2) tick();

        // Backpressure on a 2-beat op.
        set_req(0, 1'b1, 2);
        tick();
        set_req(0, 1'b0, 0);
        bus.pipe_ready_i = 1'b0;
        repeat (3) tick();
        bus.pipe_ready_i = 1'b1;
        repeat (3) tick();

        // beats=0 normalised to a single beat.
        set_req(1, 1'b1, 0);
        tick();
        set_req(1, 1'b0, 0);
        repeat (2) tick();

        // Flush at beat 1 of a 4-beat op while req1 waits.
        set_req(0, 1'b1, 4);
        tick();
        set_req(0, 1'b0, 0);
        tick();
        bus.flush_i = 1'b1;
        set_req(1, 1'b1, 1);
        tick();
        bus.flush_i = 1'b0;
        #1;
        chk("flush_idle", 128'(bus.busy_o), 128'(0));
        chk("flush_req1_acc", 128'(bus.req_ready_o), 128'(2'b10));
        tick();
        set_req(1, 1'b0, 0);
        repeat (2) tick();

        // Reset at beat 2 of a 5-beat op; pointer must return to requester 0.
        set_req(0, 1'b1, 5);
        tick();
        set_req(0, 1'b0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        set_req(0, 1'b1, 2);
        set_req(1, 1'b1, 2);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_ptr_winner", 128'(bus.req_ready_o), 128'(2'b01));
        tick();
        set_req(0, 1'b0, 0);
        set_req(1, 1'b0, 0);
        repeat (3) tick();

        // Short random mix of requests, backpressure, flush and reset.
        for (int c = 0; c < 300; c++) begin
            set_req(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
            set_req(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
            bus.pipe_ready_i = ($urandom_range(0, 9) < 7);
            bus.flush_i      = ($urandom_range(0, 19) == 0);
            rst_n            = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst_n = 1'b0;
        bus.flush_i = 1'b0;
        bus.pipe_ready_i = 1'b1;
        set_req(0, 1'b0, 0);
        set_req(1, 1'b0, 0);
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vex_issue_ctrl.md
Name: vex_issue_ctrl

Overview:
- Issue controller in front of the single-lane-group vector ALU pipe (vex_pipe).
- Arbitrates NUM_REQ requesters round-robin and latches the winning multi-beat vector operation.
- Sequences that operation to the pipe one beat (one lane-group slice) per accepted pipe handshake, then reports completion.
- Sits between the vector issue stage and vex_pipe.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- OP_WIDTH, 128, width of the opaque packed operation payload (to_vector_alu)
- BEAT_W, 4, width of beat count; max beats = 2^BEAT_W - 1
- ID_W, $clog2(NUM_REQ) (min 1), requester index width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-HIGH (asserted = 1, sampled on rising clk)
- req_valid_i  in  NUM_REQ  per-requester operation valid
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
- req_op_i  in  NUM_REQ*OP_WIDTH  per-requester operation payload
- req_beats_i  in  NUM_REQ*BEAT_W  per-requester beat count
- flush_i  in  1  abort the current operation
- pipe_valid_o  out  1  beat valid toward vex_pipe
- pipe_ready_i  in  1  vex_pipe ready
- pipe_op_o  out  OP_WIDTH  latched operation
- pipe_beat_o  out  BEAT_W  current beat index, 0-based
- pipe_last_o  out  1  current beat is the final beat
- done_o  out  1  one-cycle pulse on final beat handshake
- done_id_o  out  ID_W  requester of the completed operation
- busy_o  out  1  state == ISSUE

Behaviour:
- Reset (rst_n=1 at clk edge):
  - state=IDLE; rr pointer=0.
  - All outputs 0, including pipe_op_o and pipe_beat_o.
  - Reset mid-operation discards the operation silently; no done_o.
- Beat fire = pipe_valid_o & pipe_ready_i.
- Beat count normalisation: beats_eff = (req_beats_i==0) ? 1 : req_beats_i.
- Arbitration:
  - Grant g = first index with req_valid_i=1, searching from the rr pointer upward and wrapping.
  - On accept: pointer <= (g+1) mod NUM_REQ.
  - The pointer is unchanged when nothing is accepted.
- Accept condition:
  - Requires flush_i=0.
  - And either state==IDLE, or state==ISSUE with a final-beat fire in the same cycle (back-to-back).
  - On accept, req_ready_o[g]=1 combinationally; all other bits of req_ready_o are 0.
- IDLE:
  - pipe_valid_o=0.
  - On accept, latch op, beats_eff and g; beat counter <= 0; go to ISSUE.
- ISSUE:
  - pipe_valid_o=1; pipe_op_o=latched op; pipe_beat_o=counter; pipe_last_o=(counter==beats_eff-1).
  - Fire, not last: counter++.
  - Fire, last: done_o=1 and done_id_o=latched id in that cycle. Then load a new operation if one is accepted (stay ISSUE), else go to IDLE.
  - No fire: hold all state. pipe_op_o and pipe_beat_o stay stable while pipe_valid_o=1 and pipe_ready_i=0.
- Latency: request accepted in cycle N; beat 0 presented in cycle N+1. An op of B beats with pipe_ready_i=1 throughout completes in cycle N+B.
- Flush:
  - flush_i=1 in any state: next state IDLE; no done_o, even if the final beat fires in that cycle.
  - req_ready_o=0 that cycle.
  - The pipe still observes pipe_valid_o for that cycle; discarding its result is the consumer's job.
- done_o and done_id_o are 0 whenever no final-beat fire occurs.
- Requester payloads are don't-care when their req_valid_i=0.

Decomposition:
- vector_pkg: to_vector_alu (payload, width OP_WIDTH), issue_state_e {IDLE, ISSUE}, localparam MAX_BEATS.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, pointer, advance enable.
  - Outputs: one-hot grant, grant index, any_grant.
- vex_issue_ctrl holds the FSM, latches, beat counter and pointer register.

Test Plan:
- Reset: drive rst_n=1 with req0 valid for 2 cycles -> all outputs 0; after release, req0 (beats=3) accepted in cycle 0; pipe_beat_o = 0, 1, 2 in cycles 1-3; pipe_last_o and done_o=1 with done_id_o=0 in cycle 3.
- Round-robin: req0 and req1 continuously valid, beats=1 each -> grants alternate 0, 1, 0, 1; back-to-back, with pipe_valid_o continuously 1 and done_o every cycle.
- Backpressure: beats=2, pipe_ready_i=0 for cycles 1-3 -> pipe_beat_o stays 0 and pipe_op_o stays stable; done_o occurs at cycle 5.
- beats=0 -> treated as 1: single beat with pipe_last_o=1, done_o one cycle after accept.
- Flush: flush_i at beat 1 of a 4-beat op, with req1 valid -> no done_o and req_ready_o=0 that cycle; IDLE next cycle; req1 accepted the cycle after.
- Reset mid-op at beat 2 of 5 -> no done_o; pointer returns to 0, so req0 wins the next arbitration over req1.
